// File: rtl/cpu_datapath.sv
// Register/ALU datapath of the 8-bit accumulator CPU: AC/DR/AR/PC/IR and Z/C update on posedge clk; bus, ALU and memory lines are combinational.
// No backpressure: every strobe present at a rising edge is applied in that cycle.
module cpu_datapath #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MUX_sel,
  input  logic [1:0]        ALU_op,
  input  logic              AR_load,
  input  logic              PC_load,
  input  logic              PC_inc,
  input  logic              AC_load,
  input  logic              ZC_load,
  input  logic              IR_load,
  input  logic              DR_load,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] Instruction,
  output logic              flag_z,
  output logic              flag_c,
  output logic [DATA_W-1:0] dbg_ac,
  output logic [ADDR_W-1:0] dbg_pc
);

  localparam logic [1:0] SEL_AC = 2'b00;
  localparam logic [1:0] SEL_DR = 2'b01;
  localparam logic [1:0] SEL_PC = 2'b10;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_PASS = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  logic [DATA_W-1:0] ac, dr, ir, bus, res;
  logic [ADDR_W-1:0] ar, pc;
  logic              z, c, cout, zero;
  logic [DATA_W:0]   sum;

  // PC is zero-extended onto the bus; the slice assignment also covers ADDR_W == DATA_W.
  always_comb begin
    bus = '0;
    case (MUX_sel)
      SEL_AC:  bus = ac;
      SEL_DR:  bus = dr;
      SEL_PC:  bus[ADDR_W-1:0] = pc;
      default: bus = mem_rdata;
    endcase
  end

  assign sum = {1'b0, ac} + {1'b0, dr};

  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (ALU_op)
      OP_ADD: begin
        res  = sum[DATA_W-1:0];
        cout = sum[DATA_W];
      end
      OP_PASS: res = dr;
      OP_AND:  res = ac & dr;
      default: res = ~ac;
    endcase
  end

  assign zero = (res == '0);

  // All strobes sample pre-edge values, so simultaneous loads never see each other's results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ac <= '0;
      dr <= '0;
      ir <= '0;
      ar <= '0;
      pc <= PC_RESET;
      z  <= 1'b0;
      c  <= 1'b0;
    end else begin
      if (AR_load) ar <= bus[ADDR_W-1:0];
      if (DR_load) dr <= bus;
      if (IR_load) ir <= bus;
      if (AC_load) ac <= res;
      if (ZC_load) begin
        z <= zero;
        c <= cout;
      end
      if (PC_load)     pc <= bus[ADDR_W-1:0];
      else if (PC_inc) pc <= pc + PC_STEP;
    end
  end

  assign mem_addr    = ar;
  assign mem_wdata   = bus;
  assign mem_we      = mem_wr;
  assign Instruction = ir;
  assign flag_z      = z;
  assign flag_c      = c;
  assign dbg_ac      = ac;
  assign dbg_pc      = pc;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed plus randomized bench for cpu_datapath against an arithmetic reference model.
module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] MUX_sel, ALU_op;
  logic       AR_load, PC_load, PC_inc, AC_load, ZC_load, IR_load, DR_load, mem_wr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr, mem_wdata, Instruction, dbg_ac, dbg_pc;
  logic       mem_we, flag_z, flag_c;

  // strobe bit positions: {AR, PC_load, PC_inc, AC, ZC, IR, DR}
  localparam logic [6:0] S_AR  = 7'b1000000;
  localparam logic [6:0] S_PCL = 7'b0100000;
  localparam logic [6:0] S_PCI = 7'b0010000;
  localparam logic [6:0] S_AC  = 7'b0001000;
  localparam logic [6:0] S_ZC  = 7'b0000100;
  localparam logic [6:0] S_IR  = 7'b0000010;
  localparam logic [6:0] S_DR  = 7'b0000001;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_ac, m_dr, m_ir, m_ar, m_pc;
  logic       m_z, m_c;

  cpu_datapath dut (
    .clk(clk), .rst(rst), .MUX_sel(MUX_sel), .ALU_op(ALU_op),
    .AR_load(AR_load), .PC_load(PC_load), .PC_inc(PC_inc), .AC_load(AC_load),
    .ZC_load(ZC_load), .IR_load(IR_load), .DR_load(DR_load), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .Instruction(Instruction), .flag_z(flag_z), .flag_c(flag_c),
    .dbg_ac(dbg_ac), .dbg_pc(dbg_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ac = 8'h00; m_dr = 8'h00; m_ir = 8'h00; m_ar = 8'h00; m_pc = 8'h00;
    m_z = 1'b0; m_c = 1'b0;
  endtask

  function automatic logic [7:0] model_bus(input logic [1:0] sel, input logic [7:0] rd);
    case (sel)
      2'd0:    return m_ac;
      2'd1:    return m_dr;
      2'd2:    return m_pc;
      default: return rd;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_ac"}, dbg_ac, m_ac);
    chk({tag, "_pc"}, dbg_pc, m_pc);
    chk({tag, "_ir"}, Instruction, m_ir);
    chk({tag, "_addr"}, mem_addr, m_ar);
    chk({tag, "_z"}, flag_z, m_z);
    chk({tag, "_c"}, flag_c, m_c);
  endtask

  task automatic drive(input logic [1:0] sel, input logic [1:0] op, input logic [6:0] s,
                       input logic [7:0] rd, input logic wr);
    MUX_sel = sel; ALU_op = op; mem_rdata = rd; mem_wr = wr;
    {AR_load, PC_load, PC_inc, AC_load, ZC_load, IR_load, DR_load} = s;
  endtask

  // One clock: drive at negedge, check combinational lines, predict, check registers after the edge.
  task automatic step(input logic [1:0] sel, input logic [1:0] op, input logic [6:0] s,
                      input logic [7:0] rd, input logic wr);
    logic [7:0] b, res;
    logic       cout;
    int         total;
    @(negedge clk);
    drive(sel, op, s, rd, wr);
    #1;
    b = model_bus(sel, rd);
    chk("bus", mem_wdata, b);
    chk("we", mem_we, wr);
    chk("addr_pre", mem_addr, m_ar);
    total = int'(m_ac) + int'(m_dr);
    cout = 1'b0;
    case (op)
      2'd0: begin res = 8'(total % 256); cout = (total > 255); end
      2'd1: res = m_dr;
      2'd2: res = m_ac & m_dr;
      default: res = ~m_ac;
    endcase
    @(posedge clk);
    if (s[6]) m_ar = b;
    if (s[0]) m_dr = b;
    if (s[1]) m_ir = b;
    if (s[3]) m_ac = res;
    if (s[2]) begin m_z = (res == 8'h00); m_c = cout; end
    if (s[5]) m_pc = b;
    else if (s[4]) m_pc = m_pc + 8'h01;
    #1;
    check_regs("step");
  endtask

  task automatic load_dr(input logic [7:0] v);
    step(2'd3, 2'd0, S_DR, v, 1'b0);
  endtask

  task automatic load_ac(input logic [7:0] v);
    load_dr(v);
    step(2'd0, 2'd1, S_AC, 8'h00, 1'b0);
  endtask

  initial begin
    drive(2'd0, 2'd0, 7'd0, 8'h00, 1'b0);
    rst = 1'b0;
    model_reset();
    #2;
    check_regs("reset0");
    @(negedge clk);
    rst = 1'b1;

    // Random activity, then an asynchronous reset between edges.
    for (int i = 0; i < 6; i++)
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    drive(2'd3, 2'd0, 7'h7f, 8'hc3, 1'b1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_regs("areset");
    chk("areset_we", mem_we, 1'b1);
    @(negedge clk);
    drive(2'd0, 2'd0, 7'd0, 8'h00, 1'b0);
    #1;
    check_regs("reset_held");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(2'd3, 2'd0, 7'd0, 8'hff, 1'b0);

    // Fetch
    step(2'd3, 2'd0, S_IR | S_PCI, 8'h01, 1'b0);
    chk("fetch_ir", Instruction, 8'h01);
    chk("fetch_pc", dbg_pc, 8'h01);
    step(2'd2, 2'd0, S_AR, 8'h00, 1'b0);
    chk("fetch_ar", mem_addr, 8'h01);

    // ADD with carry, then ADD to zero with carry
    load_ac(8'hf0); load_dr(8'h20);
    step(2'd0, 2'd0, S_AC | S_ZC, 8'h00, 1'b0);
    chk("add1_ac", dbg_ac, 8'h10); chk("add1_c", flag_c, 1'b1); chk("add1_z", flag_z, 1'b0);
    load_ac(8'h80); load_dr(8'h80);
    step(2'd0, 2'd0, S_AC | S_ZC, 8'h00, 1'b0);
    chk("add2_ac", dbg_ac, 8'h00); chk("add2_c", flag_c, 1'b1); chk("add2_z", flag_z, 1'b1);

    // COM / AND / PASS
    load_ac(8'hff);
    step(2'd0, 2'd3, S_AC | S_ZC, 8'h00, 1'b0);
    chk("com_ac", dbg_ac, 8'h00); chk("com_z", flag_z, 1'b1); chk("com_c", flag_c, 1'b0);
    load_ac(8'h3c); load_dr(8'h0f);
    step(2'd0, 2'd2, S_AC, 8'h00, 1'b0);
    chk("and_ac", dbg_ac, 8'h0c); chk("and_z_hold", flag_z, 1'b1);
    load_dr(8'ha5);
    step(2'd0, 2'd1, S_AC, 8'h00, 1'b0);
    chk("pass_ac", dbg_ac, 8'ha5); chk("pass_z_hold", flag_z, 1'b1);

    // PC wrap and load-over-increment priority
    step(2'd3, 2'd0, S_PCL, 8'hff, 1'b0);
    step(2'd0, 2'd0, S_PCI, 8'h00, 1'b0);
    chk("pc_wrap", dbg_pc, 8'h00);
    load_dr(8'h40);
    step(2'd1, 2'd0, S_PCL | S_PCI, 8'h00, 1'b0);
    chk("pc_prio", dbg_pc, 8'h40);

    // Store presentation
    load_ac(8'h5a);
    step(2'd3, 2'd0, S_AR, 8'h10, 1'b0);
    step(2'd0, 2'd0, 7'd0, 8'h00, 1'b1);
    chk("st_addr", mem_addr, 8'h10); chk("st_wdata", mem_wdata, 8'h5a); chk("st_we", mem_we, 1'b1);

    // AC and DR loaded together: ALU uses pre-edge DR
    load_ac(8'h01); load_dr(8'h02);
    step(2'd3, 2'd0, S_AC | S_DR, 8'h07, 1'b0);
    chk("sim_ac", dbg_ac, 8'h03);
    step(2'd1, 2'd0, 7'd0, 8'h00, 1'b0);
    chk("sim_dr", mem_wdata, 8'h07);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Register/ALU datapath of the 8-bit accumulator CPU.
- Sits directly downstream of the control unit: consumes MUX_sel, ALU_op and the *_load / PC_inc strobes.
- Returns Instruction, flag_z and flag_c to the control unit, and drives the program/data memory address and write-data lines.
- Holds AC, DR, AR, PC, IR and the Z/C flag register; all updates on posedge clk. The control unit changes its outputs on negedge, so strobes are stable at the datapath's sampling edge.

Parameters:
- DATA_W, 8, width of bus, AC, DR, IR and ALU.
- ADDR_W, 8, width of AR, PC and mem_addr (must satisfy ADDR_W <= DATA_W).
- PC_RESET, 0, PC value after reset.

Ports:
- clk  input  1  system clock, posedge-active for this block
- rst  input  1  reset, asynchronous, active-low
- MUX_sel  input  2  bus source: 00 AC, 01 DR, 10 PC, 11 memory
- ALU_op  input  2  00 ADD, 01 PASS, 10 AND, 11 COMPLEMENT
- AR_load  input  1  AR <= bus
- PC_load  input  1  PC <= bus
- PC_inc  input  1  PC <= PC + 1
- AC_load  input  1  AC <= ALU result
- ZC_load  input  1  Z/C <= ALU flags
- IR_load  input  1  IR <= bus
- DR_load  input  1  DR <= bus
- mem_wr  input  1  store request from control (STOA)
- mem_rdata  input  DATA_W  asynchronous-read memory data at mem_addr
- mem_addr  output  ADDR_W  = AR
- mem_wdata  output  DATA_W  = bus
- mem_we  output  1  = mem_wr (combinational pass-through)
- Instruction  output  DATA_W  = IR
- flag_z  output  1  Z flag register
- flag_c  output  1  C flag register
- dbg_ac  output  DATA_W  = AC
- dbg_pc  output  ADDR_W  = PC

Behaviour:
- Reset (rst low, async): AC=DR=IR=0, AR=0, PC=PC_RESET, Z=0, C=0. All register-driven outputs follow immediately; mem_we still reflects mem_wr. Reset mid-operation discards any in-flight load; after release, the first posedge honours strobes normally.
- Bus (combinational):
  - 00 -> AC
  - 01 -> DR
  - 10 -> PC zero-extended to DATA_W
  - 11 -> mem_rdata
- ALU (combinational, operands AC and DR):
  - ADD: {cout, res} = AC + DR, computed DATA_W+1 wide.
  - PASS: res = DR, cout = 0.
  - AND: res = AC & DR, cout = 0.
  - COM: res = ~AC, cout = 0.
  - zero = (res == 0).
- Register updates at posedge, each strobe independent; several may be asserted in the same cycle:
  - AR_load: AR <= bus[ADDR_W-1:0].
  - DR_load: DR <= bus.
  - IR_load: IR <= bus.
  - AC_load: AC <= res. AC and DR loaded in the same cycle: the ALU uses the pre-edge DR and AC values.
  - ZC_load: Z <= zero, C <= cout. Independent of AC_load; flags computed from pre-edge operands.
- PC:
  - PC_load and PC_inc both high: PC_load wins, no increment.
  - Increment wraps 2^ADDR_W-1 -> 0, no flag side-effect.
- AR_load with MUX_sel=AC: AR takes the pre-edge AC (address from accumulator). Loading a register from itself via the bus holds its value.
- No strobe asserted: all registers hold.
- Memory write timing is owned by the memory; the datapath only presents mem_addr/mem_wdata/mem_we. During STOA, control drives MUX_sel=00 so mem_wdata=AC.

Test Plan:
- Reset: drive strobes randomly, assert rst low between edges -> all registers 0 immediately, PC=PC_RESET; release, no strobes for 3 clocks -> values hold.
- Fetch: PC=0x00, mem_rdata=0x01, MUX_sel=11 with IR_load and PC_inc high for one clock -> Instruction=0x01, dbg_pc=0x01. Then MUX_sel=10 with AR_load -> mem_addr=0x01.
- ADD with carry: AC=0xF0, DR=0x20, ALU_op=00, AC_load+ZC_load -> AC=0x10, C=1, Z=0. Then AC=0x80, DR=0x80 -> AC=0x00, C=1, Z=1.
- COM/AND/PASS:
  - AC=0xFF, COM -> AC=0x00, Z=1, C=0.
  - AC=0x3C, DR=0x0F, AND -> 0x0C.
  - DR=0xA5, PASS -> AC=0xA5.
  - ZC_load low during any of these -> flags unchanged.
- PC boundaries: PC=0xFF with PC_inc -> 0x00. PC_load and PC_inc together with bus=0x40 (MUX_sel=01, DR=0x40) -> PC=0x40.
- Store/simultaneity: AC=0x5A, AR=0x10, MUX_sel=00, mem_wr=1 -> mem_addr=0x10, mem_wdata=0x5A, mem_we=1. DR_load and AC_load with ADD in the same clock (AC=1, DR=2, bus from mem_rdata=7) -> AC=3, DR=7.
